// File: rtl/adc_sample_fifo.sv
// Elastic ADC sample buffer: the codec side never stalls, and samples arriving while full are dropped and counted.
// Optional output priming (hold output until PREFILL samples are buffered): define ADC_SAMPLE_FIFO_PREFILL_EN.
module adc_sample_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int PREFILL = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PREFILL < 1 || PREFILL > DEPTH) begin : g_bad_params
    $error("adc_sample_fifo: DEPTH must be a power of two >= 2 and PREFILL in 1..DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_nxt;
  logic              push;
  logic              pop;
  logic              full;
  logic              accept;
  logic              drop;

  always_comb begin
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    full      = (level == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    accept    = push && (!full || pop);
    drop      = push && full && !pop;
    level_nxt = level;
    if (accept && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !accept)
      level_nxt = level - LW'(1);
  end

  // Sample storage carries no reset; out_data is only meaningful while out_valid=1.
  always_ff @(posedge clock) begin
    if (accept && !clear)
      mem[wr_ptr] <= in_data;
  end

  assign out_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      in_ready <= 1'b1;
      if (clear) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        level        <= '0;
        overflow     <= 1'b0;
        overflow_cnt <= '0;
      end else begin
        if (accept)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        level <= level_nxt;
        if (drop) begin
          overflow <= 1'b1;
          if (overflow_cnt != '1)
            overflow_cnt <= overflow_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ADC_SAMPLE_FIFO_PREFILL_EN
  localparam logic [0:0] PRIMING   = 1'b0;
  localparam logic [0:0] STREAMING = 1'b1;

  logic [0:0] state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= PRIMING;
    end else if (clear) begin
      state <= PRIMING;
    end else begin
      case (state)
        PRIMING:   if (level_nxt >= LW'(PREFILL)) state <= STREAMING;
        STREAMING: if (pop && !accept && level_nxt == '0) state <= PRIMING;
        default:   state <= PRIMING;
      endcase
    end
  end

  assign out_valid = (state == STREAMING) && (level != '0);
`else
  assign out_valid = (level != '0);
`endif

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo: stimulus queues expected samples, a negedge monitor checks each transfer.
module tb_adc_sample_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              clear;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [CNT_W-1:0]  overflow_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  adc_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .PREFILL(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .overflow    (overflow),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [DATA_W-1:0] d, input bit stored);
    in_valid = 1'b1;
    in_data  = d;
    if (stored) exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (level == '0) break;
      step();
    end
    check({name, "_level_zero"}, 64'(level), 64'd0);
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Inputs change only just after posedge, so what the monitor sees at negedge is what the next edge transfers.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got 0x%0h, expected no sample", out_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_err++;
          $display("FAIL out_data: got 0x%0h, expected 0x%0h", out_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_overflow_cnt", 64'(overflow_cnt), 64'd0);
    reset = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_level", 64'(level), 64'd0);

`ifndef ADC_SAMPLE_FIFO_PREFILL_EN
    out_ready = 1'b1;
    push_one(32'h0000_0011, 1'b1);
    check("pass_out_valid", 64'(out_valid), 64'd1);
    check("pass_out_data", 64'(out_data), 64'h11);
    step();
    check("pass_level", 64'(level), 64'd0);
    check("pass_drained", 64'(exp_q.size()), 64'd0);
`else
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_one(32'h400 + 32'(i), 1'b1);
      check("prime_out_valid_low", 64'(out_valid), 64'd0);
    end
    push_one(32'h403, 1'b1);
    check("prime_out_valid_high", 64'(out_valid), 64'd1);
    wait_empty("prime_drain", 20);
    push_one(32'h404, 1'b0);
    check("reprime_level", 64'(level), 64'd1);
    check("reprime_out_valid", 64'(out_valid), 64'd0);
    step();
    check("reprime_hold", 64'(out_valid), 64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
`endif

    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      if (i < DEPTH) exp_q.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_cnt", 64'(overflow_cnt), 64'd2);
    check("ovf_head", 64'(out_data), 64'h100);

    in_valid = 1'b1; in_data = 32'h0000_AAAA; out_ready = 1'b1;
    exp_q.push_back(in_data);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("fullpp_level", 64'(level), 64'd16);
    check("fullpp_cnt", 64'(overflow_cnt), 64'd2);
    check("fullpp_head", 64'(out_data), 64'h101);
    out_ready = 1'b1;
    wait_empty("ovf_drain", 40);

    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'b1;
      in_data   = 32'h2000 + 32'(i);
      out_ready = (i % 4) != 3;
      exp_q.push_back(in_data);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_empty("wrap_drain", 40);

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(32'h300 + 32'(i), 1'b1);
    check("clr_pre_level", 64'(level), 64'd5);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'h0000_DEAD;
    exp_q.delete();
    step();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_level", 64'(level), 64'd0);
    check("clr_out_valid", 64'(out_valid), 64'd0);
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_cnt", 64'(overflow_cnt), 64'd0);
    check("clr_in_ready", 64'(in_ready), 64'd1);
`ifndef ADC_SAMPLE_FIFO_PREFILL_EN
    out_ready = 1'b1;
    push_one(32'h0000_0077, 1'b1);
    wait_empty("clr_after", 10);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
